// File: rtl/fir_mult_arbiter.sv
// fir_mult_arbiter
// Round-robin scheduler that shares one fixed-latency pipelined multiplier
// between NUM_REQ FIR tap channels. The scheduler accepts at most one operand
// pair per cycle and registers it into the multiplier. A tag pipeline follows
// every in-flight product, so each result is returned to the channel that
// issued it.
//
// Optional feature: define FIR_ARB_LOCK_EN to add the req_lock input. A
// granted requester with its lock bit set keeps top priority while it stays
// valid, which supports back-to-back tap bursts.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   req_valid       per-requester operand-pair valid (held until accepted)
//   req_a, req_b    packed operands; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_lock        (FIR_ARB_LOCK_EN only) per-requester priority lock
//   req_ready       one-hot grant, combinational from req_valid and pointer
//   mult_in_valid   registered operand valid to the multiplier
//   mult_a, mult_b  registered operands to the multiplier
//   mult_result     multiplier product, PIPE_STAGES cycles after mult_in_valid
//   resp_valid      one-hot owner of the product present this cycle
//   resp_data       product passed through unmodified
//   busy            any product in flight or any grant this cycle
module fir_mult_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PIPE_STAGES = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
`ifdef FIR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]              req_lock,
`endif
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            mult_in_valid,
    output logic [DATA_WIDTH-1:0]           mult_a,
    output logic [DATA_WIDTH-1:0]           mult_b,
    input  logic [2*DATA_WIDTH-1:0]         mult_result,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic [2*DATA_WIDTH-1:0]         resp_data,
    output logic                            busy
);

    localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TAG_DEPTH = PIPE_STAGES + 1;
    localparam int unsigned TAIL      = PIPE_STAGES;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]       ptr_q;
    logic [ID_W-1:0]       ptr_d;
    logic [NUM_REQ-1:0]    grant_c;
    logic [ID_W-1:0]       grant_id_c;
    logic                  xfer_c;
    logic                  hold_c;
    logic [DATA_WIDTH-1:0] sel_a_c;
    logic [DATA_WIDTH-1:0] sel_b_c;
    logic [TAG_DEPTH-1:0]  tag_vld_q;
    logic [ID_W-1:0]       tag_id_q [TAG_DEPTH];

    // Round-robin search: first scan ptr..NUM_REQ-1, then wrap to 0..ptr-1.
    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        xfer_c     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!xfer_c && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
                xfer_c     = 1'b1;
                grant_id_c = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!xfer_c && req_valid[i] && (ID_W'(i) < ptr_q)) begin
                xfer_c     = 1'b1;
                grant_id_c = ID_W'(i);
            end
        end
        grant_c[grant_id_c] = xfer_c;
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_a_c = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b_c = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A locked grant keeps the pointer on the winner instead of advancing.
`ifdef FIR_ARB_LOCK_EN
    assign hold_c = req_lock[grant_id_c];
`else
    assign hold_c = 1'b0;
`endif

    // Next priority pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer_c) begin
            if (hold_c) begin
                ptr_d = grant_id_c;
            end else if (grant_id_c == LAST_ID) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_id_c + ID_W'(1);
            end
        end
    end

    // Pointer, multiplier operand registers and tag pipeline.
    // The tag pipeline is one entry deeper than the multiplier because the
    // operand register adds one cycle ahead of the multiplier itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            mult_in_valid <= 1'b0;
            mult_a        <= '0;
            mult_b        <= '0;
            tag_vld_q     <= '0;
            for (int s = 0; s < TAG_DEPTH; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            mult_in_valid <= xfer_c;
            if (xfer_c) begin
                mult_a <= sel_a_c;
                mult_b <= sel_b_c;
            end
            tag_vld_q   <= {tag_vld_q[TAG_DEPTH-2:0], xfer_c};
            tag_id_q[0] <= grant_id_c;
            for (int s = 1; s < TAG_DEPTH; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    // The tail tag lines up with the product leaving the multiplier.
    always_comb begin
        resp_valid                 = '0;
        resp_valid[tag_id_q[TAIL]] = tag_vld_q[TAIL];
    end

    assign resp_data = mult_result;
    assign req_ready = grant_c;
    assign busy      = (|tag_vld_q) | (|grant_c);

endmodule

// File: tb/tb_fir_mult_arbiter.sv
// Bench for fir_mult_arbiter: directed scenarios followed by constrained
// random traffic. A small behavioural multiplier closes the loop, and a
// reference model built from the scheduling rules predicts every grant,
// operand and response.
module tb_fir_mult_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int P     = 3;
    localparam int SCHED = 4096;

    logic                  clk;
    logic                  reset;
    logic [N-1:0]          rv;
`ifdef FIR_ARB_LOCK_EN
    logic [N-1:0]          lock;
`endif
    logic signed [DW-1:0]  a_op [N];
    logic signed [DW-1:0]  b_op [N];
    logic [N*DW-1:0]       req_a;
    logic [N*DW-1:0]       req_b;
    logic [N-1:0]          req_ready;
    logic                  mult_in_valid;
    logic [DW-1:0]         mult_a;
    logic [DW-1:0]         mult_b;
    logic [2*DW-1:0]       mult_result;
    logic [N-1:0]          resp_valid;
    logic [2*DW-1:0]       resp_data;
    logic                  busy;

    logic signed [2*DW-1:0] mpipe [P];

    int              n_checks;
    int              n_fail;
    int              cyc;
    int              last_g;
    int              m_ptr;
    logic            m_miv;
    logic [DW-1:0]   m_ma;
    logic [DW-1:0]   m_mb;
    logic [N-1:0]    exp_rv [SCHED];
    logic [2*DW-1:0] exp_rd [SCHED];
    logic [N-1:0]    pend;

    fir_mult_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .PIPE_STAGES(P)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (rv),
        .req_a        (req_a),
        .req_b        (req_b),
`ifdef FIR_ARB_LOCK_EN
        .req_lock     (lock),
`endif
        .req_ready    (req_ready),
        .mult_in_valid(mult_in_valid),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_result  (mult_result),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = a_op[i];
            req_b[i*DW +: DW] = b_op[i];
        end
    end

    // Behavioural multiplier with P cycles of latency.
    always_ff @(posedge clk) begin
        mpipe[0] <= 32'($signed(mult_a)) * 32'($signed(mult_b));
        for (int k = 1; k < P; k++) begin
            mpipe[k] <= mpipe[k-1];
        end
    end
    assign mult_result = mpipe[P-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock cycle: predict, compare, then advance model and clock.
    task automatic step();
        int                     g;
        logic [N-1:0]           exp_rdy;
        logic                   busy_exp;
        logic                   lk;
        logic signed [2*DW-1:0] prod;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && rv[idx]) g = idx;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        busy_exp = (rv != '0);
        for (int d = 0; d <= P; d++) begin
            if (exp_rv[cyc+d] != '0) busy_exp = 1'b1;
        end
        #2;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("mult_in_valid", 64'(mult_in_valid), 64'(m_miv));
        if (m_miv) begin
            check("mult_a", 64'(mult_a), 64'(m_ma));
            check("mult_b", 64'(mult_b), 64'(m_mb));
        end
        check("resp_valid", 64'(resp_valid), 64'(exp_rv[cyc]));
        if (exp_rv[cyc] != '0) begin
            check("resp_data", 64'(resp_data), 64'(exp_rd[cyc]));
        end
        check("busy", 64'(busy), 64'(busy_exp));
        if (g >= 0) begin
            lk = 1'b0;
`ifdef FIR_ARB_LOCK_EN
            lk = lock[g];
`endif
            prod = 32'(a_op[g]) * 32'(b_op[g]);
            exp_rv[cyc+1+P] = exp_rdy;
            exp_rd[cyc+1+P] = prod;
            m_miv = 1'b1;
            m_ma  = a_op[g];
            m_mb  = b_op[g];
            m_ptr = lk ? g : (g + 1) % N;
        end else begin
            m_miv = 1'b0;
        end
        last_g = g;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset for one edge; everything in flight is forgotten.
    task automatic do_reset();
        rv    = '0;
        reset = 1'b1;
        #2;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_mult_in_valid", 64'(mult_in_valid), 64'(0));
        check("rst_mult_a", 64'(mult_a), 64'(0));
        check("rst_mult_b", 64'(mult_b), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
        for (int i = 0; i < SCHED; i++) begin
            exp_rv[i] = '0;
            exp_rd[i] = '0;
        end
        m_ptr = 0;
        m_miv = 1'b0;
        m_ma  = '0;
        m_mb  = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        last_g   = -1;
        reset    = 1'b0;
        rv       = '0;
        pend     = '0;
`ifdef FIR_ARB_LOCK_EN
        lock     = '0;
`endif
        for (int i = 0; i < N; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        #1;
        do_reset();

        // Single request from requester 2: 3 * -5.
        rv      = 4'b0100;
        a_op[2] = 16'sd3;
        b_op[2] = -16'sd5;
        step();
        rv = '0;
        repeat (P + 2) step();

        // All requesters held valid: grants rotate 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_op[i] = DW'(i + 1);
            b_op[i] = 16'sd10;
        end
        rv = 4'b1111;
        repeat (8) step();
        rv = '0;
        repeat (P + 2) step();

        // Wrap: grant 2, then 3 and 0 compete; 3 first, then 0.
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_op[i] = DW'($urandom);
            b_op[i] = DW'($urandom);
        end
        rv = 4'b0100;
        step();
        rv = 4'b1001;
        step();
        rv = 4'b0001;
        step();
        rv = 4'b1111;
        step();
        rv = '0;
        repeat (P + 2) step();

        // Reset two cycles after a transfer discards the in-flight product.
        do_reset();
        rv = 4'b0010;
        step();
        rv = '0;
        repeat (2) step();
        do_reset();
        repeat (P + 3) step();

        // Requester 1 at cycles 0, 1 and 3.
        rv = 4'b0010;
        step();
        a_op[1] = -16'sd7;
        step();
        rv = '0;
        step();
        rv = 4'b0010;
        b_op[1] = 16'sd32767;
        step();
        rv = '0;
        repeat (P + 2) step();

`ifdef FIR_ARB_LOCK_EN
        // Requester 2 locked for three transfers while 0 and 3 wait.
        do_reset();
        rv = 4'b0010;
        step();
        rv      = 4'b1101;
        lock[2] = 1'b1;
        step();
        step();
        lock[2] = 1'b0;
        step();
        rv = 4'b1001;
        step();
        rv = 4'b0001;
        step();
        rv   = '0;
        lock = '0;
        repeat (P + 2) step();
`endif

        // Random traffic; requesters hold valid and operands until accepted.
        do_reset();
        pend = '0;
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    a_op[i] = DW'($urandom);
                    b_op[i] = DW'($urandom);
                end
`ifdef FIR_ARB_LOCK_EN
                lock[i] = 1'($urandom_range(0, 1));
`endif
            end
            rv = pend;
            step();
            if (last_g >= 0) pend[last_g] = 1'b0;
        end
        rv = '0;
        repeat (P + 2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
